mips_multicycle_ctrl: RTL
=========================

# mips_multicycle_ctrl

Parametrised multicycle MIPS control unit, the successor to the fixed ten-state controller. It sequences fetch/decode/execute/memory/writeback per instruction class and waits on a memory ready handshake with a bounded timeout. It traps on illegal opcodes and memory timeouts, and exports access-size and branch-condition qualifiers to the datapath. It sits between the instruction register/memory interface and the datapath muxes, ALU and register file.

## Interface
- XLEN, 32: instruction width; opcode field is instr[XLEN-1 -: 6].
- TIMEOUT, 15: maximum wait cycles for mem_ready before trapping, 1..255.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- instr  in  XLEN  memory read data; captured as the instruction in FETCH.
- mem_ready  in  1  memory access complete this cycle.
- trap_clr  in  1  leave TRAP; sampled only in TRAP.
- reg_dst, jump, branch, mem_read, mem_write, mem_to_reg, alu_src, reg_write  out  1 each  datapath controls.
- alu_op  out  2  00 add, 01 compare/sub, 10 funct-decoded.
- ir_write, pc_write  out  1 each  instruction-register load; PC+4 update.
- mem_size  out  2  00 word, 01 half, 10 byte.
- branch_cond  out  2  00 beq, 01 bne, 10 bgtz.
- trap  out  1  high while in TRAP.
- trap_cause  out  2  01 illegal opcode, 10 memory timeout; held until trap_clr.
- busy  out  1  high in every state except FETCH.

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, I_EXEC, I_WB, R_EXEC, R_WB, BRANCH, JUMP, TRAP.
- FETCH: mem_read=1, alu_src=0, alu_op=00. When mem_ready: ir_write=1 and pc_write=1 for that cycle, op_q<=instr opcode, go to DECODE.
- DECODE classifies op_q:
  - load (100011/100001/100000 → word/half/byte) or store (101011/101001/101000) → MEM_ADDR.
  - I-ALU (001000, 001100, 001101, 001010) → I_EXEC.
  - R-type (000000) → R_EXEC.
  - beq 000100, bne 000101, bgtz 000111 → BRANCH.
  - j 000010 → JUMP.
  - anything else → TRAP with cause 01.
- MEM_ADDR: alu_src=1, alu_op=00; next MEM_RD for loads, MEM_WR for stores.
- MEM_RD: mem_read=1, alu_src=1; on mem_ready → MEM_WB.
- MEM_WB: mem_to_reg=1, reg_write=1, reg_dst=0; → FETCH.
- MEM_WR: mem_write=1, alu_src=1; on mem_ready → FETCH. mem_write is never asserted in any other state.
- I_EXEC: alu_src=1, alu_op=00 → I_WB. I_WB: alu_src=1, reg_write=1, reg_dst=0 → FETCH.
- R_EXEC: alu_op=10 → R_WB. R_WB: alu_op=10, reg_dst=1, reg_write=1 → FETCH.
- BRANCH: alu_op=01, branch=1 → FETCH.
- JUMP: jump=1 → FETCH.
- mem_size and branch_cond are decoded from op_q in every state; they are 00 for other opcodes.
- Wait counter:
  - Cleared on entry to FETCH, MEM_RD and MEM_WR; increments each waiting cycle without mem_ready.
  - If the count reaches TIMEOUT with mem_ready still low → TRAP with cause 10.
  - mem_ready in the same cycle as reaching the limit wins: normal transition, no trap.
- TRAP: all datapath controls 0, trap=1. trap_clr → FETCH, clearing trap_cause.
- Any control not listed for a state is 0; no x/z is ever driven.

## Timing
- rst low: state=FETCH, op_q=0, counter=0, trap_cause=00. All outputs forced 0 while rst is low, including mem_read; FETCH outputs appear from the first cycle after release.
- Moore outputs: combinational decode of the registered state and op_q. The only exceptions are ir_write/pc_write, which are qualified by mem_ready in FETCH.
- Cycles with zero-wait memory: R-type/I-ALU 4, load 5, store 4, branch 3, jump 3, illegal opcode 2 before entering TRAP.
- Each wait cycle adds exactly one cycle. Timeout trap occurs in the cycle after the TIMEOUT-th non-ready wait cycle.
- Reset asserted mid-instruction aborts immediately; no partial reg_write or mem_write is issued after rst falls.

## Structure
- Shared package mips_ctrl_pkg holds the state enum, opcode localparams, alu_op / mem_size / branch_cond / trap_cause codes, and the wait-counter width $clog2(TIMEOUT+1).
- One sub-module, mips_opcode_class: combinational opcode→{class, mem_size, branch_cond, legal}, reused later by the hazard unit.

## Test plan
- lw 0x8C000000 with mem_ready tied high → states FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB; reg_write and mem_to_reg only in cycle 5; mem_size=00.
- sb 0xA0000000 with mem_ready low for 3 cycles in MEM_WR → mem_write high for exactly 4 cycles, then FETCH; mem_size=10.
- bne 0x14000000 → branch=1 with branch_cond=01 for one cycle in cycle 3; add 0x00000020 → reg_dst=1, reg_write=1 in cycle 4.
- Opcode 111111 → trap=1, trap_cause=01 in cycle 3; hold 5 cycles, pulse trap_clr → FETCH, cause 00.
- TIMEOUT=15, mem_ready never asserted in FETCH → trap_cause=10 after 15 wait cycles; mem_ready on the 15th wait cycle → DECODE, no trap.
- rst pulled low during MEM_WR → all outputs 0 at once; after release FETCH with mem_read=1.

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM states,
// opcode classes, opcode values and the control-field encodings.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEM_ADDR,
      S_MEM_RD,
      S_MEM_WB,
      S_MEM_WR,
      S_I_EXEC,
      S_I_WB,
      S_R_EXEC,
      S_R_WB,
      S_BRANCH,
      S_JUMP,
      S_TRAP
   } state_t;

   typedef enum logic [2:0] {
      CL_LOAD,
      CL_STORE,
      CL_IALU,
      CL_RTYPE,
      CL_BRANCH,
      CL_JUMP,
      CL_ILLEGAL
   } op_class_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_BGTZ  = 6'b000111;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_LH    = 6'b100001;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_SH    = 6'b101001;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] MSZ_WORD = 2'b00;
   localparam logic [1:0] MSZ_HALF = 2'b01;
   localparam logic [1:0] MSZ_BYTE = 2'b10;

   localparam logic [1:0] BC_BEQ  = 2'b00;
   localparam logic [1:0] BC_BNE  = 2'b01;
   localparam logic [1:0] BC_BGTZ = 2'b10;

   localparam logic [1:0] TC_NONE    = 2'b00;
   localparam logic [1:0] TC_ILLEGAL = 2'b01;
   localparam logic [1:0] TC_TIMEOUT = 2'b10;

   // Wait-counter width: must hold counts 0..timeout.
   function automatic int wait_cnt_w(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> memory/datapath bundle. The master side is the controller.
interface mips_ctrl_if #(parameter int XLEN = 32);
   logic [XLEN-1:0] instr;
   logic            mem_ready;
   logic            trap_clr;

   logic            reg_dst;
   logic            jump;
   logic            branch;
   logic            mem_read;
   logic            mem_write;
   logic            mem_to_reg;
   logic            alu_src;
   logic            reg_write;
   logic [1:0]      alu_op;
   logic            ir_write;
   logic            pc_write;
   logic [1:0]      mem_size;
   logic [1:0]      branch_cond;
   logic            trap;
   logic [1:0]      trap_cause;
   logic            busy;

   modport master (
      input  instr, mem_ready, trap_clr,
      output reg_dst, jump, branch, mem_read, mem_write, mem_to_reg, alu_src,
             reg_write, alu_op, ir_write, pc_write, mem_size, branch_cond,
             trap, trap_cause, busy
   );

   modport slave (
      output instr, mem_ready, trap_clr,
      input  reg_dst, jump, branch, mem_read, mem_write, mem_to_reg, alu_src,
             reg_write, alu_op, ir_write, pc_write, mem_size, branch_cond,
             trap, trap_cause, busy
   );
endinterface

// File: rtl/mips_multicycle_ctrl_opcode_class.sv
// Pure opcode classifier; kept separate so the hazard unit can share it.
module mips_opcode_class
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] op,
   output op_class_t  cls,
   output logic [1:0] mem_size,
   output logic [1:0] branch_cond,
   output logic       legal
);

   // Map each opcode to its class plus access size / branch qualifier.
   always_comb begin
      cls         = CL_ILLEGAL;
      mem_size    = MSZ_WORD;
      branch_cond = BC_BEQ;
      legal       = 1'b1;
      case (op)
         OP_LW:   cls = CL_LOAD;
         OP_LH:   begin cls = CL_LOAD;  mem_size = MSZ_HALF; end
         OP_LB:   begin cls = CL_LOAD;  mem_size = MSZ_BYTE; end
         OP_SW:   cls = CL_STORE;
         OP_SH:   begin cls = CL_STORE; mem_size = MSZ_HALF; end
         OP_SB:   begin cls = CL_STORE; mem_size = MSZ_BYTE; end
         OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: cls = CL_IALU;
         OP_RTYPE: cls = CL_RTYPE;
         OP_BEQ:  cls = CL_BRANCH;
         OP_BNE:  begin cls = CL_BRANCH; branch_cond = BC_BNE;  end
         OP_BGTZ: begin cls = CL_BRANCH; branch_cond = BC_BGTZ; end
         OP_J:    cls = CL_JUMP;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences each instruction class, waits on
// the memory ready handshake with a bounded timeout and traps on illegal
// opcodes or memory timeouts. Outputs are a Moore decode of state/op_q,
// forced to zero while rst is low.
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 15   // legal range 1..255
) (
   input  logic       clk,
   input  logic       rst,
   mips_ctrl_if.master bus
);

   localparam int             CW       = wait_cnt_w(TIMEOUT);
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

   state_t          state;
   logic [5:0]      op_q;
   logic [CW-1:0]   cnt;
   logic [1:0]      trap_cause_q;

   op_class_t       cls;
   logic [1:0]      msz;
   logic [1:0]      bcond;
   logic            legal;
   logic            timed_out;

   mips_opcode_class u_class (
      .op          (op_q),
      .cls         (cls),
      .mem_size    (msz),
      .branch_cond (bcond),
      .legal       (legal)
   );

   // The current non-ready wait cycle is the TIMEOUT-th one.
   assign timed_out = !bus.mem_ready && (cnt == CNT_LAST);

   // State, captured opcode, wait counter and trap cause. The counter is
   // cleared on every transition and only grows while a wait state stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_FETCH;
         op_q         <= 6'b0;
         cnt          <= '0;
         trap_cause_q <= TC_NONE;
      end else begin
         cnt <= '0;
         case (state)
            S_FETCH: begin
               if (bus.mem_ready) begin
                  op_q  <= bus.instr[XLEN-1 -: 6];
                  state <= S_DECODE;
               end else if (timed_out) begin
                  state        <= S_TRAP;
                  trap_cause_q <= TC_TIMEOUT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DECODE: begin
               if (!legal) begin
                  state        <= S_TRAP;
                  trap_cause_q <= TC_ILLEGAL;
               end else begin
                  case (cls)
                     CL_LOAD, CL_STORE: state <= S_MEM_ADDR;
                     CL_IALU:           state <= S_I_EXEC;
                     CL_RTYPE:          state <= S_R_EXEC;
                     CL_BRANCH:         state <= S_BRANCH;
                     CL_JUMP:           state <= S_JUMP;
                     default: begin
                        state        <= S_TRAP;
                        trap_cause_q <= TC_ILLEGAL;
                     end
                  endcase
               end
            end
            S_MEM_ADDR: state <= (cls == CL_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
               if (bus.mem_ready) begin
                  state <= S_MEM_WB;
               end else if (timed_out) begin
                  state        <= S_TRAP;
                  trap_cause_q <= TC_TIMEOUT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_MEM_WR: begin
               if (bus.mem_ready) begin
                  state <= S_FETCH;
               end else if (timed_out) begin
                  state        <= S_TRAP;
                  trap_cause_q <= TC_TIMEOUT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_I_EXEC: state <= S_I_WB;
            S_R_EXEC: state <= S_R_WB;
            S_MEM_WB, S_I_WB, S_R_WB, S_BRANCH, S_JUMP: state <= S_FETCH;
            S_TRAP: begin
               if (bus.trap_clr) begin
                  state        <= S_FETCH;
                  trap_cause_q <= TC_NONE;
               end
            end
            default: state <= S_FETCH;
         endcase
      end
   end

   logic       reg_dst, jump, branch, mem_read, mem_write, mem_to_reg;
   logic       alu_src, reg_write, ir_write, pc_write, trap, busy;
   logic [1:0] alu_op, mem_size, branch_cond, trap_cause;

   // Moore decode of the state; only ir_write/pc_write look at mem_ready.
   always_comb begin
      reg_dst     = 1'b0;
      jump        = 1'b0;
      branch      = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_to_reg  = 1'b0;
      alu_src     = 1'b0;
      reg_write   = 1'b0;
      alu_op      = ALU_ADD;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      trap        = 1'b0;
      busy        = (state != S_FETCH);
      mem_size    = msz;
      branch_cond = bcond;
      trap_cause  = trap_cause_q;
      case (state)
         S_FETCH: begin
            mem_read = 1'b1;
            ir_write = bus.mem_ready;
            pc_write = bus.mem_ready;
         end
         S_MEM_ADDR: alu_src = 1'b1;
         S_MEM_RD: begin
            mem_read = 1'b1;
            alu_src  = 1'b1;
         end
         S_MEM_WB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            alu_src   = 1'b1;
         end
         S_I_EXEC: alu_src = 1'b1;
         S_I_WB: begin
            alu_src   = 1'b1;
            reg_write = 1'b1;
         end
         S_R_EXEC: alu_op = ALU_FUNCT;
         S_R_WB: begin
            alu_op    = ALU_FUNCT;
            reg_dst   = 1'b1;
            reg_write = 1'b1;
         end
         S_BRANCH: begin
            alu_op = ALU_SUB;
            branch = 1'b1;
         end
         S_JUMP: jump = 1'b1;
         S_TRAP: trap = 1'b1;
         default: ;
      endcase
      if (!rst) begin
         reg_dst     = 1'b0;
         jump        = 1'b0;
         branch      = 1'b0;
         mem_read    = 1'b0;
         mem_write   = 1'b0;
         mem_to_reg  = 1'b0;
         alu_src     = 1'b0;
         reg_write   = 1'b0;
         alu_op      = 2'b00;
         ir_write    = 1'b0;
         pc_write    = 1'b0;
         trap        = 1'b0;
         busy        = 1'b0;
         mem_size    = 2'b00;
         branch_cond = 2'b00;
         trap_cause  = 2'b00;
      end
   end

   assign bus.reg_dst     = reg_dst;
   assign bus.jump        = jump;
   assign bus.branch      = branch;
   assign bus.mem_read    = mem_read;
   assign bus.mem_write   = mem_write;
   assign bus.mem_to_reg  = mem_to_reg;
   assign bus.alu_src     = alu_src;
   assign bus.reg_write   = reg_write;
   assign bus.alu_op      = alu_op;
   assign bus.ir_write    = ir_write;
   assign bus.pc_write    = pc_write;
   assign bus.mem_size    = mem_size;
   assign bus.branch_cond = branch_cond;
   assign bus.trap        = trap;
   assign bus.trap_cause  = trap_cause;
   assign bus.busy        = busy;

endmodule
